// File: rtl/ftoi_pkg.sv
// Shared types and binary32 field constants for the pipelined float-to-integer converter.
package ftoi_pkg;

  localparam int unsigned F32_BIAS   = 127;
  localparam int unsigned F32_MANT_W = 23;
  localparam int unsigned MAG_W      = 33;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;

  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    ZERO   = 3'd1,
    INF    = 3'd2,
    NAN    = 3'd3,
    OVF    = 3'd4
  } sc_e;

  // Magnitude is sized for the widest legal result; narrower builds leave the top bits zero.
  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic             guard;
    logic             sticky;
    logic             lsb;
    sc_e              code;
    rm_e              rm;
    logic             is_unsigned;
  } s1_t;

endpackage

// File: rtl/ftoi_round.sv
// Round and saturate a decoded stage-1 payload into an INT_W-bit integer with exception flags.
module ftoi_round
  import ftoi_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  s1_t              p,
  output logic [INT_W-1:0] y,
  output logic             invalid,
  output logic             inexact
);

  localparam int unsigned RW = MAG_W + 1;
  localparam logic [RW-1:0] S_POS = RW'((64'd1 << (INT_W - 1)) - 64'd1);
  localparam logic [RW-1:0] S_NEG = RW'(64'd1 << (INT_W - 1));
  localparam logic [RW-1:0] U_POS = RW'((64'd1 << INT_W) - 64'd1);
  localparam logic [INT_W-1:0] Y_SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] Y_SMIN = {1'b1, {(INT_W-1){1'b0}}};

  logic             inc;
  logic             any_frac;
  logic             in_range;
  logic [RW-1:0]    mr;
  logic [RW-1:0]    lim;
  logic [RW-1:0]    res;
  logic [INT_W-1:0] y_pos_sat;
  logic [INT_W-1:0] y_neg_sat;
  logic             unused_hi;

  always_comb begin
    any_frac = p.guard | p.sticky;
    inc      = 1'b0;
    unique case (p.rm)
      RM_RNE:  inc = p.guard & (p.sticky | p.lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = p.sign & any_frac;
      RM_RUP:  inc = !p.sign & any_frac;
      default: inc = 1'b0;
    endcase

    // One spare bit so an all-ones magnitude rounding up cannot wrap back into range.
    mr = {1'b0, p.mag} + RW'(inc);

    if (p.is_unsigned) lim = p.sign ? '0 : U_POS;
    else               lim = p.sign ? S_NEG : S_POS;
    in_range = (mr <= lim);

    y_pos_sat = p.is_unsigned ? '1 : Y_SMAX;
    y_neg_sat = p.is_unsigned ? '0 : Y_SMIN;

    res       = p.sign ? RW'(-mr) : mr;
    unused_hi = ^res[RW-1:INT_W];

    y       = '0;
    invalid = 1'b0;
    inexact = 1'b0;
    unique case (p.code)
      ZERO: y = '0;
      NAN: begin
        y       = y_pos_sat;
        invalid = 1'b1;
      end
      INF, OVF: begin
        y       = p.sign ? y_neg_sat : y_pos_sat;
        invalid = 1'b1;
      end
      default: begin
        if (in_range) begin
          y       = res[INT_W-1:0];
          inexact = any_frac;
        end else begin
          y       = p.sign ? y_neg_sat : y_pos_sat;
          invalid = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage binary32 to INT_W-bit integer converter with rounding modes, IEEE flags and
// valid/ready flow control (stage 1 decodes/aligns, stage 2 rounds/saturates).
module ftoi_pipe
  import ftoi_pkg::*;
#(
  parameter int INT_W       = 32,
  parameter bit UNSIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rm,
  input  logic             is_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] y,
  output logic             flag_invalid,
  output logic             flag_inexact
);

  localparam logic signed [8:0] EU_MAX = 9'(INT_W);
  localparam logic signed [8:0] BIAS   = 9'(F32_BIAS);

  logic                  adv1;
  logic                  adv2;
  logic                  s1_valid_q, s1_valid_d;
  logic                  s2_valid_q, s2_valid_d;
  s1_t                   s1_q, s1_d, dec;
  logic [INT_W-1:0]      y_q, y_d, rnd_y;
  logic                  inv_q, inv_d, rnd_inv;
  logic                  inx_q, inx_d, rnd_inx;

  logic [7:0]            e;
  logic [F32_MANT_W-1:0] m;
  logic signed [8:0]     eu;
  logic [87:0]           wide;
  logic [87:0]           shifted;

  // Bit 55 of wide carries weight 2^0 before shifting, so after a left shift by eu the
  // integer part sits at [87:55], guard at [54] and sticky bits below it.
  always_comb begin
    e       = x[30:23];
    m       = x[22:0];
    eu      = $signed({1'b0, e}) - BIAS;
    wide    = {32'b0, 1'b1, m, 32'b0};
    shifted = '0;

    dec             = '0;
    dec.sign        = x[31];
    dec.rm          = rm_e'(rm);
    dec.is_unsigned = UNSIGNED_EN ? is_unsigned : 1'b0;
    dec.code        = NORMAL;

    if (e == '0) begin
      dec.code = ZERO;
    end else if (e == '1) begin
      dec.code = (m != '0) ? NAN : INF;
    end else if (eu < 9'sd0) begin
      dec.guard  = (eu == -9'sd1);
      dec.sticky = (eu < -9'sd1) | ((eu == -9'sd1) & (m != '0));
    end else if (eu > EU_MAX) begin
      dec.code = OVF;
    end else begin
      shifted    = wide << eu[5:0];
      dec.mag    = shifted[87:55];
      dec.guard  = shifted[54];
      dec.sticky = |shifted[53:0];
    end
    dec.lsb = dec.mag[0];
  end

  always_comb begin
    adv2       = !s2_valid_q | out_ready;
    adv1       = !s1_valid_q | adv2;
    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    s1_d       = (adv1 & in_valid) ? dec : s1_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    y_d        = (adv2 & s1_valid_q) ? rnd_y   : y_q;
    inv_d      = (adv2 & s1_valid_q) ? rnd_inv : inv_q;
    inx_d      = (adv2 & s1_valid_q) ? rnd_inx : inx_q;
  end

  ftoi_round #(
    .INT_W(INT_W)
  ) u_round (
    .p      (s1_q),
    .y      (rnd_y),
    .invalid(rnd_inv),
    .inexact(rnd_inx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      y_q        <= '0;
      inv_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      y_q        <= y_d;
      inv_q      <= inv_d;
      inx_q      <= inx_d;
    end
  end

  assign in_ready     = adv1;
  assign out_valid    = s2_valid_q;
  assign y            = y_q;
  assign flag_invalid = inv_q;
  assign flag_inexact = inx_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: 32- and 16-bit instances driven in lockstep, checked against a value-level model.
module tb_ftoi_pipe;

  typedef struct packed {
    logic        inv;
    logic        inx;
    logic [31:0] y;
  } exp_t;

  typedef struct packed {
    logic [31:0] x;
    logic [1:0]  rm;
    logic        u;
    logic [31:0] y;
    logic        inv;
    logic        inx;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] x = '0;
  logic [1:0]  rm = '0;
  logic        is_unsigned = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready32, out_valid32, inv32, inx32;
  logic [31:0] y32;
  logic        in_ready16, out_valid16, inv16, inx16;
  logic [15:0] y16;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ftoi_pipe #(.INT_W(32), .UNSIGNED_EN(1'b1)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready32), .x(x), .rm(rm),
    .is_unsigned(is_unsigned), .out_valid(out_valid32), .out_ready(out_ready), .y(y32),
    .flag_invalid(inv32), .flag_inexact(inx32)
  );

  ftoi_pipe #(.INT_W(16), .UNSIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready16), .x(x), .rm(rm),
    .is_unsigned(is_unsigned), .out_valid(out_valid16), .out_ready(out_ready), .y(y16),
    .flag_invalid(inv16), .flag_inexact(inx16)
  );

  // Rounds the exact real value of the operand as a signed number, then clamps to the range.
  function automatic exp_t model(input logic [31:0] xv, input logic [1:0] rmv, input logic u,
                                 input int w);
    exp_t   r;
    longint lo, hi, mask, sig, ip, rem, half, v;
    int     e, k, fc;
    logic   s;
    r    = '0;
    s    = xv[31];
    e    = int'(xv[30:23]);
    lo   = u ? 64'sd0 : -(longint'(1) << (w - 1));
    hi   = u ? (longint'(1) << w) - 1 : (longint'(1) << (w - 1)) - 1;
    mask = (longint'(1) << w) - 1;
    ip   = 0;
    fc   = 0;
    if (e == 0) return r;
    if (e == 255) begin
      r.inv = 1'b1;
      v     = (xv[22:0] != 0 || !s) ? hi : lo;
      r.y   = 32'(v & mask);
      return r;
    end
    k   = e - 150;
    sig = longint'({1'b1, xv[22:0]});
    if (k > 17) begin
      r.inv = 1'b1;
      v     = s ? lo : hi;
      r.y   = 32'(v & mask);
      return r;
    end
    if (k >= 0) begin
      ip = sig << k;
    end else if (k >= -24) begin
      ip   = sig >> (-k);
      rem  = sig - (ip << (-k));
      half = longint'(1) << (-k - 1);
      fc   = (rem == 0) ? 0 : (rem < half) ? 1 : (rem == half) ? 2 : 3;
    end else begin
      fc = 1;
    end
    case (rmv)
      2'd0: begin
        v = ip + longint'((fc == 3) || (fc == 2 && ip[0]));
        v = s ? -v : v;
      end
      2'd1:    v = s ? -ip : ip;
      2'd2:    v = s ? -(ip + longint'(fc != 0)) : ip;
      default: v = s ? -ip : ip + longint'(fc != 0);
    endcase
    if (v < lo || v > hi) begin
      r.inv = 1'b1;
      v     = (v < lo) ? lo : hi;
    end else begin
      r.inx = (fc != 0);
    end
    r.y = 32'(v & mask);
    return r;
  endfunction

  function automatic logic [31:0] rand_x();
    int          sel;
    logic [7:0]  ev;
    logic [22:0] mv;
    sel = $urandom_range(0, 19);
    ev  = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(100, 162));
    case ($urandom_range(0, 3))
      0:       mv = '0;
      1:       mv = 23'd1 << $urandom_range(0, 22);
      default: mv = 23'($urandom);
    endcase
    return {1'($urandom), ev, mv};
  endfunction

  task automatic convert(input logic [31:0] xv, input logic [1:0] rmv, input logic u,
                         output logic [31:0] y32o, output logic inv32o, output logic inx32o,
                         output logic [15:0] y16o, output logic inv16o, output logic inx16o,
                         output int lat);
    @(negedge clk);
    in_valid    = 1'b1;
    x           = xv;
    rm          = rmv;
    is_unsigned = u;
    out_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid32 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    y32o   = y32;
    inv32o = inv32;
    inx32o = inx32;
    y16o   = y16;
    inv16o = inv16;
    inx16o = inx16;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid16 !== 1'b0)
      $display("FAIL reset_out_valid got %b/%b want 0", out_valid32, out_valid16);
    else passed++;
    checks++;
    if (y32 !== '0 || y16 !== '0) $display("FAIL reset_y got %h/%h want 0", y32, y16);
    else passed++;
    checks++;
    if ({inv32, inx32, inv16, inx16} !== 4'b0)
      $display("FAIL reset_flags got %b%b%b%b want 0000", inv32, inx32, inv16, inx16);
    else passed++;
    checks++;
    if (in_ready32 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready32);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    vec_t tbl [15] = '{
      '{32'h40200000, 2'd0, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h40200000, 2'd1, 1'b0, 32'h00000002, 1'b0, 1'b1},
      '{32'h40200000, 2'd3, 1'b0, 32'h00000003, 1'b0, 1'b1},
      '{32'h40400000, 2'd0, 1'b0, 32'h00000003, 1'b0, 1'b0},
      '{32'h40400000, 2'd2, 1'b0, 32'h00000003, 1'b0, 1'b0},
      '{32'h40400000, 2'd3, 1'b0, 32'h00000003, 1'b0, 1'b0},
      '{32'hC0200000, 2'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1},
      '{32'hC0200000, 2'd2, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b1},
      '{32'hBECCCCCD, 2'd0, 1'b1, 32'h00000000, 1'b0, 1'b1},
      '{32'h4F000000, 2'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h4F000000, 2'd0, 1'b1, 32'h80000000, 1'b0, 1'b0},
      '{32'hCF000000, 2'd0, 1'b0, 32'h80000000, 1'b0, 1'b0},
      '{32'h7FC00000, 2'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 2'd0, 1'b0, 32'h80000000, 1'b1, 1'b0},
      '{32'h00000001, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0}
    };
    logic [31:0] ya;
    logic [15:0] yb;
    logic        ia, xa, ib, xb;
    int          lat;
    exp_t        e16;
    for (int i = 0; i < 15; i++) begin
      convert(tbl[i].x, tbl[i].rm, tbl[i].u, ya, ia, xa, yb, ib, xb, lat);
      e16 = model(tbl[i].x, tbl[i].rm, tbl[i].u, 16);
      checks++;
      if (lat !== 2) $display("FAIL dir%0d_latency got %0d want 2", i, lat);
      else passed++;
      checks++;
      if ({ya, ia, xa} !== {tbl[i].y, tbl[i].inv, tbl[i].inx})
        $display("FAIL dir%0d_y32 x=%h got y=%h inv=%b inx=%b want y=%h inv=%b inx=%b", i,
                 tbl[i].x, ya, ia, xa, tbl[i].y, tbl[i].inv, tbl[i].inx);
      else passed++;
      checks++;
      if ({yb, ib, xb} !== {e16.y[15:0], e16.inv, e16.inx})
        $display("FAIL dir%0d_y16 x=%h got y=%h inv=%b inx=%b want y=%h inv=%b inx=%b", i,
                 tbl[i].x, yb, ib, xb, e16.y[15:0], e16.inv, e16.inx);
      else passed++;
    end
    convert(32'h47000000, 2'd0, 1'b0, ya, ia, xa, yb, ib, xb, lat);
    checks++;
    if ({yb, ib, xb} !== {16'h7FFF, 1'b1, 1'b0})
      $display("FAIL w16_32768 got y=%h inv=%b inx=%b want y=7fff inv=1 inx=0", yb, ib, xb);
    else passed++;
    checks++;
    if ({ya, ia, xa} !== {32'd32768, 1'b0, 1'b0})
      $display("FAIL w32_32768 got y=%h inv=%b inx=%b want y=00008000 inv=0 inx=0", ya, ia, xa);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] fl [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
    int          sent = 0;
    int          got = 0;
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      in_valid    = (sent < 6);
      x           = fl[(sent < 6) ? sent : 0];
      rm          = 2'd0;
      is_unsigned = 1'b0;
      out_ready   = !(c >= 2 && c <= 5);
      #1;
      if (c >= 1 && c <= 5) begin
        checks++;
        if (in_ready32 !== (c == 1))
          $display("FAIL b2b_in_ready c=%0d got %b want %b", c, in_ready32, c == 1);
        else passed++;
      end
      if (hold) begin
        checks++;
        if (out_valid32 !== 1'b1 || y32 !== held)
          $display("FAIL b2b_stall_hold got v=%b y=%h want v=1 y=%h", out_valid32, y32, held);
        else passed++;
      end
      if (out_valid32 && out_ready) begin
        checks++;
        if (y32 !== 32'(got + 1) || y16 !== 16'(got + 1))
          $display("FAIL b2b_order got %h/%h want %0d", y32, y16, got + 1);
        else passed++;
        got++;
      end
      hold = out_valid32 && !out_ready;
      held = y32;
      if (in_valid && in_ready32) sent++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 6) $display("FAIL b2b_count got %0d want 6", got);
    else passed++;
    #1;
    checks++;
    if (out_valid32 !== 1'b0) $display("FAIL b2b_no_dup got out_valid=%b want 0", out_valid32);
    else passed++;
  endtask

  task automatic test_random();
    exp_t        q32[$];
    exp_t        q16[$];
    exp_t        e32, e16;
    int          sent = 0;
    int          got = 0;
    int          n = 300;
    logic        hold = 1'b0;
    logic [31:0] held = '0;
    for (int c = 0; c < 4000 && got < n; c++) begin
      @(negedge clk);
      in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      if (in_valid) begin
        x           = rand_x();
        rm          = 2'($urandom);
        is_unsigned = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (hold) begin
        checks++;
        if (out_valid32 !== 1'b1 || y32 !== held)
          $display("FAIL rnd_stall_hold got v=%b y=%h want v=1 y=%h", out_valid32, y32, held);
        else passed++;
      end
      if (out_valid32 && out_ready) begin
        e32 = (q32.size() > 0) ? q32.pop_front() : '0;
        e16 = (q16.size() > 0) ? q16.pop_front() : '0;
        checks++;
        if ({y32, inv32, inx32} !== {e32.y, e32.inv, e32.inx})
          $display("FAIL rnd_y32 #%0d got y=%h inv=%b inx=%b want y=%h inv=%b inx=%b", got,
                   y32, inv32, inx32, e32.y, e32.inv, e32.inx);
        else passed++;
        checks++;
        if ({out_valid16, y16, inv16, inx16} !== {1'b1, e16.y[15:0], e16.inv, e16.inx})
          $display("FAIL rnd_y16 #%0d got v=%b y=%h inv=%b inx=%b want v=1 y=%h inv=%b inx=%b",
                   got, out_valid16, y16, inv16, inx16, e16.y[15:0], e16.inv, e16.inx);
        else passed++;
        got++;
      end
      hold = out_valid32 && !out_ready;
      held = y32;
      if (in_valid && in_ready32) begin
        q32.push_back(model(x, rm, is_unsigned, 32));
        q16.push_back(model(x, rm, is_unsigned, 16));
        sent++;
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== n) $display("FAIL rnd_timeout got %0d results want %0d", got, n);
    else passed++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] ya;
    logic [15:0] yb;
    logic        ia, xa, ib, xb;
    int          lat;
    int          stale = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    x         = 32'h40A00000;
    out_ready = 1'b1;
    @(negedge clk);
    x = 32'h40C00000;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid16 !== 1'b0)
      $display("FAIL rst_async_out_valid got %b/%b want 0", out_valid32, out_valid16);
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (out_valid32 || out_valid16) stale++;
    end
    checks++;
    if (stale !== 0) $display("FAIL rst_stale got %0d stale outputs want 0", stale);
    else passed++;
    convert(32'h40E00000, 2'd0, 1'b0, ya, ia, xa, yb, ib, xb, lat);
    checks++;
    if (lat !== 2 || ya !== 32'd7 || yb !== 16'd7)
      $display("FAIL rst_first_out got lat=%0d y=%h/%h want lat=2 y=7", lat, ya, yb);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d before timeout", passed, checks);
    $fatal(1);
  end

endmodule
